memory_writeback_stage: RTL
===========================

# memory_writeback_stage

Memory stage plus Memory→Writeback pipeline register of the 5-stage RV32I core. Consumes the M-stage control/data bundle (RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, RdM, PCPlus4M) and a funct3M field, and performs byte/half/word data-memory accesses against an internal synchronous RAM. It also registers the W-stage bundle consumed by the result mux and the register file. Misaligned accesses are suppressed and flagged.

## Interface
- WIDTH, 32, datapath width (only 32 supported)
- DEPTH_WORDS, 1024, data RAM depth in 32-bit words (power of two); ADDR_W = log2(DEPTH_WORDS)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- RegWriteM  in  1  register-file write enable from M
- ResultSrcM  in  2  result select: 00 ALU, 01 memory load, 10 PC+4, 11 reserved (treated as 00)
- MemWriteM  in  1  store enable
- funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ALUResultM  in  WIDTH  effective byte address / ALU result
- WriteDataM  in  WIDTH  store data (rs2), LSBs used for B/H
- RdM  in  5  destination register
- PCPlus4M  in  WIDTH  PC+4 of the instruction
- RegWriteW  out  1  registered write enable (forced 0 on misaligned load)
- ResultSrcW  out  2  registered ResultSrcM
- ReadDataW  out  WIDTH  extended load data
- ALUResultW  out  WIDTH  registered ALUResultM
- RdW  out  5  registered RdM
- PCPlus4W  out  WIDTH  registered PCPlus4M
- MisalignW  out  1  registered misaligned/illegal-access flag

## Operation
- RAM: DEPTH_WORDS × 32, four byte lanes, little-endian. Word index = ALUResultM[ADDR_W+1:2]; byte offset = ALUResultM[1:0]; higher address bits ignored (addresses alias modulo 4·DEPTH_WORDS).
- RAM contents are not reset; rst clears only the W register.
- Store (MemWriteM=1): SB writes lane offset with WriteDataM[7:0]; SH writes lanes {off+1,off} with WriteDataM[15:0]; SW writes all lanes. Other lanes unchanged.
- Load (ResultSrcM=01): read word at index, select lane(s) by offset; B/H sign-extend, BU/HU zero-extend, W passes through.
- Misaligned: H/HU with off[0]=1, W with off≠00. Illegal: funct3 ∉ {000,001,010} on store, ∉ {000,001,010,100,101} on load. Either case: no RAM write, ReadDataW=0, MisalignW=1, RegWriteW=0 if it was a load, else RegWriteW=RegWriteM.
- Not a load: ReadDataW=0. Neither load nor store: MisalignW=0 regardless of funct3/address.
- MemWriteM=1 with ResultSrcM=01 (not produced by decoder): store performed; ReadDataW returns pre-store data (read-before-write).
- All other W outputs are straight registered copies of their M inputs.

## Timing
- Single-cycle stage: inputs sampled at edge N appear on W outputs after edge N; RAM write commits at the same edge N.
- Load at edge N+1 to an address stored at edge N returns the new data (no bypass needed).
- Synchronous read: RAM output feeds the extend logic only through the W register; no combinational M→W path.
- rst at edge N: RegWriteW, ResultSrcW, ReadDataW, ALUResultW, RdW, PCPlus4W, MisalignW all 0 after edge N; any store presented in that cycle is discarded (RAM write gated by !rst).
- No stall/flush inputs; a bubble is expressed upstream as RegWriteM=0, MemWriteM=0.

## Test plan
- Reset: hold rst with MemWriteM=1, addr 0x10, data 0xDEADBEEF, 1 cycle; release, LW 0x10 -> all W outputs 0 during reset; RAM word 0x10 unchanged from prior contents.
- SW/LW: SW 0x12345678 @0x20, next cycle LW @0x20 -> ReadDataW=0x12345678, RegWriteW=1, MisalignW=0, one cycle after load presented.
- Byte/half lanes: SW 0x00000000 @0x40; SB 0x80 @0x41; SH 0xBEEF @0x42 -> LW @0x40 = 0xBEEF8000; LB @0x41 = 0xFFFFFF80; LBU @0x41 = 0x00000080; LH @0x42 = 0xFFFFBEEF; LHU @0x42 = 0x0000BEEF.
- Misaligned: SW 0xAAAAAAAA @0x50 then SW 0x55555555 @0x51 -> second store MisalignW=1, LW @0x50 still 0xAAAAAAAA; LH @0x53 with RegWriteM=1 -> RegWriteW=0, ReadDataW=0, MisalignW=1.
- Aliasing: DEPTH_WORDS=1024, SW 0xCAFEF00D @0x1000 -> LW @0x0 = 0xCAFEF00D.
- Passthrough: ResultSrcM=10, PCPlus4M=0x104, RdM=5, ALUResultM=0x7, RegWriteM=1 -> next cycle PCPlus4W=0x104, RdW=5, ALUResultW=0x7, ResultSrcW=10, ReadDataW=0, MisalignW=0.

Source files
------------

// File: rtl/memory_writeback_stage_if.sv
// M-stage request bundle and registered W-stage bundle of the memory/writeback stage.
// master drives the M side and observes W; slave is the stage itself.
interface memory_writeback_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             RegWriteM;
    logic [1:0]       ResultSrcM;
    logic             MemWriteM;
    logic [2:0]       funct3M;
    logic [WIDTH-1:0] ALUResultM;
    logic [WIDTH-1:0] WriteDataM;
    logic [4:0]       RdM;
    logic [WIDTH-1:0] PCPlus4M;

    logic             RegWriteW;
    logic [1:0]       ResultSrcW;
    logic [WIDTH-1:0] ReadDataW;
    logic [WIDTH-1:0] ALUResultW;
    logic [4:0]       RdW;
    logic [WIDTH-1:0] PCPlus4W;
    logic             MisalignW;

    modport master (
        output RegWriteM, ResultSrcM, MemWriteM, funct3M, ALUResultM, WriteDataM, RdM, PCPlus4M,
        input  RegWriteW, ResultSrcW, ReadDataW, ALUResultW, RdW, PCPlus4W, MisalignW
    );

    modport slave (
        input  RegWriteM, ResultSrcM, MemWriteM, funct3M, ALUResultM, WriteDataM, RdM, PCPlus4M,
        output RegWriteW, ResultSrcW, ReadDataW, ALUResultW, RdW, PCPlus4W, MisalignW
    );
endinterface

// File: rtl/memory_writeback_stage.sv
// RV32I memory stage with internal byte-lane data RAM and the M->W pipeline register.
// RAM is read synchronously; load extension happens after the W register.
module memory_writeback_stage #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input logic                     clk,
    input logic                     rst,
    memory_writeback_stage_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        off;
    logic              is_load;
    logic              is_store;
    logic              load_legal;
    logic              store_legal;
    logic              aligned;
    logic              access_bad;
    logic              mem_we;
    logic [3:0]        be;
    logic [31:0]       wdata;

    logic [3:0][7:0]   mem [DEPTH_WORDS];
    logic [WIDTH-1:0]  rdata_q;

    logic              regwrite_q;
    logic [1:0]        resultsrc_q;
    logic [WIDTH-1:0]  aluresult_q;
    logic [4:0]        rd_q;
    logic [WIDTH-1:0]  pcplus4_q;
    logic              misalign_q;
    logic              load_ok_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;

    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    assign word_idx = bus.ALUResultM[ADDR_W+1:2];
    assign off      = bus.ALUResultM[1:0];

    always_comb begin
        is_load     = (bus.ResultSrcM == 2'b01);
        is_store    = bus.MemWriteM;
        load_legal  = 1'b0;
        store_legal = 1'b0;
        aligned     = 1'b1;
        case (bus.funct3M)
            3'b000: begin
                load_legal  = 1'b1;
                store_legal = 1'b1;
            end
            3'b001: begin
                load_legal  = 1'b1;
                store_legal = 1'b1;
                aligned     = ~off[0];
            end
            3'b010: begin
                load_legal  = 1'b1;
                store_legal = 1'b1;
                aligned     = (off == 2'b00);
            end
            3'b100: load_legal = 1'b1;
            3'b101: begin
                load_legal = 1'b1;
                aligned    = ~off[0];
            end
            default: ;
        endcase
        access_bad = (is_load && !(load_legal && aligned)) ||
                     (is_store && !(store_legal && aligned));

        // Replicate store data across lanes so the byte enables alone pick the target.
        be    = 4'hF;
        wdata = bus.WriteDataM[31:0];
        case (bus.funct3M[1:0])
            2'b00: begin
                be    = 4'b0001 << off;
                wdata = {4{bus.WriteDataM[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << off;
                wdata = {2{bus.WriteDataM[15:0]}};
            end
            default: ;
        endcase
        mem_we = is_store && !access_bad && !rst;
    end

    // Read-before-write: a simultaneous load sees the pre-store word.
    always_ff @(posedge clk) begin
        rdata_q <= mem[word_idx];
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][i] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q  <= 1'b0;
            resultsrc_q <= 2'b00;
            aluresult_q <= '0;
            rd_q        <= 5'd0;
            pcplus4_q   <= '0;
            misalign_q  <= 1'b0;
            load_ok_q   <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
        end else begin
            regwrite_q  <= bus.RegWriteM && !(access_bad && is_load);
            resultsrc_q <= bus.ResultSrcM;
            aluresult_q <= bus.ALUResultM;
            rd_q        <= bus.RdM;
            pcplus4_q   <= bus.PCPlus4M;
            misalign_q  <= access_bad;
            load_ok_q   <= is_load && !access_bad;
            funct3_q    <= bus.funct3M;
            off_q       <= off;
        end
    end

    always_comb begin
        byte_sel      = rdata_q[8*off_q +: 8];
        half_sel      = rdata_q[16*off_q[1] +: 16];
        bus.ReadDataW = '0;
        if (load_ok_q) begin
            case (funct3_q)
                3'b000:  bus.ReadDataW = {{24{byte_sel[7]}}, byte_sel};
                3'b001:  bus.ReadDataW = {{16{half_sel[15]}}, half_sel};
                3'b010:  bus.ReadDataW = rdata_q;
                3'b100:  bus.ReadDataW = {24'd0, byte_sel};
                3'b101:  bus.ReadDataW = {16'd0, half_sel};
                default: bus.ReadDataW = '0;
            endcase
        end
    end

    assign bus.RegWriteW  = regwrite_q;
    assign bus.ResultSrcW = resultsrc_q;
    assign bus.ALUResultW = aluresult_q;
    assign bus.RdW        = rd_q;
    assign bus.PCPlus4W   = pcplus4_q;
    assign bus.MisalignW  = misalign_q;
endmodule
